// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
// Shared constants, types and helpers for the configuration latch loader.
//   WORD_W    : width of one configuration word / latch data bus
//   NUM_WORDS : number of latch groups (width of the one-hot enable vector)
//   IDX_W     : word-index width, 2**IDX_W must be >= NUM_WORDS
// The CHECK state is only reachable when CONFIG_LOADER_CHECKSUM_EN is defined.
// -----------------------------------------------------------------------------
package cfg_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 30;
   localparam int IDX_W     = 5;

   // Index of the final latch group; the word counter stops here.
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_WORD = 3'd1,
      SETUP     = 3'd2,
      STROBE    = 3'd3,
      HOLD      = 3'd4,
      CHECK     = 3'd5,
      DONE      = 3'd6
   } state_t;

   // Running XOR checksum step: fold one accepted word into the accumulator.
   function automatic word_t csum_next(input word_t acc, input word_t w);
      return acc ^ w;
   endfunction

endpackage

// File: rtl/cfg_onehot_dec.sv
// -----------------------------------------------------------------------------
// cfg_onehot_dec
// Registered index-to-one-hot decoder for the latch enables.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset, clears every enable at once
//   i_idx    : latch group index
//   i_strobe : request a strobe for i_idx on the next clock
//   o_en     : registered one-hot enable vector, all zeros when no strobe
// Indices at or above NUM never raise a bit, so o_en is at most one-hot.
// -----------------------------------------------------------------------------
module cfg_onehot_dec
   import cfg_pkg::*;
#(
   parameter int NUM = NUM_WORDS,
   parameter int IW  = IDX_W
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [IW-1:0]  i_idx,
   input  logic           i_strobe,
   output logic [NUM-1:0] o_en
);

   logic [NUM-1:0] w_dec;
   logic [NUM-1:0] r_en;

   // Decode the index into a one-hot vector, gated by the strobe request.
   always_comb begin
      w_dec = {NUM{1'b0}};
      for (int i = 0; i < NUM; i++) begin
         if (i_strobe && (i_idx == IW'(i))) begin
            w_dec[i] = 1'b1;
         end else begin
            w_dec[i] = 1'b0;
         end
      end
   end

   // Enable register: the latch bank sees a glitch-free, flop-driven strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en <= {NUM{1'b0}};
      end else begin
         r_en <= w_dec;
      end
   end

   assign o_en = r_en;

endmodule

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
// Write-side controller for the configuration latch bank. Accepts 32-bit words
// over a valid/ready handshake and writes each one to its latch group with a
// SETUP / STROBE / HOLD sequence so data is stable around a single-cycle
// enable pulse.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   io_start        : one-cycle pulse starting a load sequence (ignored while busy)
//   io_word_valid   : word available on io_word_data
//   io_word_data    : configuration word
//   io_word_ready   : loader accepts a word this cycle
//   io_d_out        : latch data bus, holds the last accepted word
//   io_configs_en   : one-hot latch enables
//   io_busy         : sequence in progress
//   io_done         : sequence complete, held until the next accepted io_start
//   io_cfg_err      : checksum mismatch (only with CONFIG_LOADER_CHECKSUM_EN)
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN adds a CHECK state that
// accepts one extra word and compares it with the XOR of all loaded words.
// -----------------------------------------------------------------------------
module config_loader
   import cfg_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 io_start,
   input  logic                 io_word_valid,
   input  logic [WORD_W-1:0]    io_word_data,
   output logic                 io_word_ready,
   output logic [WORD_W-1:0]    io_d_out,
   output logic [NUM_WORDS-1:0] io_configs_en,
   output logic                 io_busy,
`ifdef CONFIG_LOADER_CHECKSUM_EN
   output logic                 io_cfg_err,
`endif
   output logic                 io_done
);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic             r_ready;
   word_t            r_d_out;
   logic             r_busy;
   logic             r_done;
`ifdef CONFIG_LOADER_CHECKSUM_EN
   word_t            r_csum;
   logic             r_err;
`endif

   logic             w_accept;
   logic             w_strobe;

   // r_ready is only ever high in WAIT_WORD (and CHECK), so this is the handshake.
   assign w_accept = io_word_valid && r_ready;

   // Request the strobe while in SETUP so the registered enable lines up with STROBE.
   assign w_strobe = (r_state == SETUP);

   cfg_onehot_dec #(
      .NUM (NUM_WORDS),
      .IW  (IDX_W)
   ) u_dec (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_idx    (r_idx),
      .i_strobe (w_strobe),
      .o_en     (io_configs_en)
   );

   // Load sequencer: state, word index and all registered handshake/status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_idx   <= {IDX_W{1'b0}};
         r_ready <= 1'b0;
         r_d_out <= {WORD_W{1'b0}};
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
         r_csum  <= {WORD_W{1'b0}};
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               // A word presented together with io_start is not taken: ready is still low.
               if (io_start) begin
                  r_state <= WAIT_WORD;
                  r_idx   <= {IDX_W{1'b0}};
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  r_csum  <= {WORD_W{1'b0}};
                  r_err   <= 1'b0;
`endif
               end else begin
                  r_state <= IDLE;
               end
            end
            WAIT_WORD: begin
               if (w_accept) begin
                  r_d_out <= io_word_data;
                  r_ready <= 1'b0;
                  r_state <= SETUP;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  r_csum  <= csum_next(r_csum, io_word_data);
`endif
               end else begin
                  r_state <= WAIT_WORD;
               end
            end
            SETUP: begin
               r_state <= STROBE;
            end
            STROBE: begin
               r_state <= HOLD;
            end
            HOLD: begin
               if (r_idx == LAST_IDX) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                  r_state <= CHECK;
                  r_ready <= 1'b1;
`else
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_idx   <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                  r_ready <= 1'b1;
                  r_state <= WAIT_WORD;
               end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            CHECK: begin
               // The checksum word is compared only; it never reaches the latch bus.
               if (w_accept) begin
                  r_ready <= 1'b0;
                  r_err   <= (r_csum != io_word_data);
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= CHECK;
               end
            end
`endif
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               // Unreachable encodings recover to an idle, non-busy state.
               r_state <= IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign io_word_ready = r_ready;
   assign io_d_out      = r_d_out;
   assign io_busy       = r_busy;
   assign io_done       = r_done;
`ifdef CONFIG_LOADER_CHECKSUM_EN
   assign io_cfg_err    = r_err;
`endif

endmodule
